// File: rtl/hd_timing_pkg.sv
// HD raster timing: shared constants, counter widths and genlock state type.
// The genlock path is built only when HD_TIMING_GENLOCK_EN is defined.
package hd_timing_pkg;

    // Counter widths for the pixel and line indices
    localparam int HCNT_W = 12;
    localparam int VCNT_W = 11;

    // 1080p50 raster
    localparam int T1080_H_ACTIVE = 1920;
    localparam int T1080_H_FP     = 528;
    localparam int T1080_H_SYNC   = 44;
    localparam int T1080_H_BP     = 148;
    localparam int T1080_V_ACTIVE = 1080;
    localparam int T1080_V_FP     = 4;
    localparam int T1080_V_SYNC   = 5;
    localparam int T1080_V_BP     = 36;

    // 720p50 raster
    localparam int T720_H_ACTIVE = 1280;
    localparam int T720_H_FP     = 440;
    localparam int T720_H_SYNC   = 40;
    localparam int T720_H_BP     = 220;
    localparam int T720_V_ACTIVE = 720;
    localparam int T720_V_FP     = 5;
    localparam int T720_V_SYNC   = 5;
    localparam int T720_V_BP     = 20;

    // Genlock states: normal counting, or holding in back porch for lock
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Total period from active, front porch, sync and back porch
    function automatic int tm_total(input int act, input int fp,
                                    input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/hd_pix_strobe.sv
// Pixel divider: counts clk_out cycles within a pixel period and produces
// the registered pixel strobe clock plus the pixel-advance enable.
module hd_pix_strobe
    import hd_timing_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic hd_clk_o,
    output logic adv_o,
    output logic first_o
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PIX_HALF = PW'(CLK_DIV / 2);

    logic [PW-1:0] pix_cnt_q;
    logic [PW-1:0] pix_cnt_d;
    logic          hd_clk_q;

    assign adv_o     = (pix_cnt_q == PIX_LAST);
    assign first_o   = (pix_cnt_q == '0);
    assign pix_cnt_d = adv_o ? '0 : pix_cnt_q + PW'(1);
    assign hd_clk_o  = hd_clk_q;

    // Divider count and strobe clock, high in the first half of each pixel
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pix_cnt_q <= '0;
            hd_clk_q  <= 1'b0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            hd_clk_q  <= (pix_cnt_q < PIX_HALF);
        end
    end

endmodule

// File: rtl/hd_timing_gen.sv
// HD raster timing generator (hsync/vsync/DE/counters) in the clk_out domain.
// Define HD_TIMING_GENLOCK_EN to frame-lock the vertical period to i_frame_end.
module hd_timing_gen
    import hd_timing_pkg::*;
#(
    parameter int H_ACTIVE       = 1920,
    parameter int H_FP           = 88,
    parameter int H_SYNC         = 44,
    parameter int H_BP           = 148,
    parameter int V_ACTIVE       = 1080,
    parameter int V_FP           = 4,
    parameter int V_SYNC         = 5,
    parameter int V_BP           = 36,
    parameter int CLK_DIV        = 2,
    parameter int LOCK_MAX_LINES = 64
) (
    input  logic              clk_out,
    input  logic              reset,
    input  logic              i_frame_end,
    output logic              o_hd_clk,
    output logic              o_hd_hsync,
    output logic              o_hd_vsync,
    output logic              o_hd_de,
    output logic [HCNT_W-1:0] o_h_count,
    output logic [VCNT_W-1:0] o_v_count,
    output logic              o_frame_start,
    output logic              o_locked
);

    localparam int H_TOTAL = tm_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = tm_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(H_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_LAST  = VCNT_W'(V_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT   = HCNT_W'(H_ACTIVE);
    localparam logic [VCNT_W-1:0] V_ACT   = VCNT_W'(V_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_BEG  = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] HS_END  = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCNT_W-1:0] VS_BEG  = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VS_END  = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic              pix_adv;
    logic              pix_first;
    logic [HCNT_W-1:0] h_q, h_d;
    logic [VCNT_W-1:0] v_q, v_d;

    logic              hsync_q;
    logic              vsync_q;
    logic              de_q;
    logic              fstart_q;
    logic [HCNT_W-1:0] hcnt_q;
    logic [VCNT_W-1:0] vcnt_q;

`ifdef HD_TIMING_GENLOCK_EN
    localparam int HOLD_W = (LOCK_MAX_LINES > 1) ? $clog2(LOCK_MAX_LINES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_MAX_LINES - 1);

    state_e            state_q, state_d;
    logic              flag_q, flag_d;
    logic              flag_set;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              locked_q, locked_d;

    // A pulse arriving on the wrap cycle itself still counts for that wrap
    assign flag_set = flag_q | i_frame_end;
    assign o_locked = locked_q;
`else
    localparam int unused_lock_max = LOCK_MAX_LINES;
    logic unused_frame_end;

    assign unused_frame_end = i_frame_end;
    assign o_locked         = 1'b0;
`endif

    hd_pix_strobe #(
        .CLK_DIV (CLK_DIV)
    ) u_pix (
        .clk_i    (clk_out),
        .reset_i  (reset),
        .hd_clk_o (o_hd_clk),
        .adv_o    (pix_adv),
        .first_o  (pix_first)
    );

    // Next raster position, including the hold-for-lock decision at frame end
    always_comb begin
        h_d = h_q;
        v_d = v_q;
`ifdef HD_TIMING_GENLOCK_EN
        state_d  = state_q;
        hold_d   = hold_q;
        locked_d = locked_q;
        flag_d   = flag_set;
`endif
        if (pix_adv) begin
            if (h_q != H_LAST) begin
                h_d = h_q + HCNT_W'(1);
            end else begin
                h_d = '0;
`ifdef HD_TIMING_GENLOCK_EN
                unique case (state_q)
                    ST_RUN: begin
                        if (v_q != V_LAST) begin
                            v_d = v_q + VCNT_W'(1);
                        end else if (flag_set) begin
                            v_d      = '0;
                            flag_d   = 1'b0;
                            locked_d = 1'b1;
                        end else begin
                            state_d = ST_HOLD;
                            hold_d  = '0;
                        end
                    end
                    ST_HOLD: begin
                        if (flag_set) begin
                            v_d      = '0;
                            flag_d   = 1'b0;
                            locked_d = 1'b1;
                            state_d  = ST_RUN;
                        end else if (hold_q == HOLD_LAST) begin
                            v_d      = '0;
                            locked_d = 1'b0;
                            state_d  = ST_RUN;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                    default: state_d = ST_RUN;
                endcase
`else
                v_d = (v_q == V_LAST) ? '0 : v_q + VCNT_W'(1);
`endif
            end
        end
    end

    // Raster counters and genlock state
    always_ff @(posedge clk_out) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
`ifdef HD_TIMING_GENLOCK_EN
            state_q  <= ST_RUN;
            flag_q   <= 1'b0;
            hold_q   <= '0;
            locked_q <= 1'b0;
`endif
        end else begin
            h_q <= h_d;
            v_q <= v_d;
`ifdef HD_TIMING_GENLOCK_EN
            state_q  <= state_d;
            flag_q   <= flag_d;
            hold_q   <= hold_d;
            locked_q <= locked_d;
`endif
        end
    end

    // Registered decode of the current raster position
    always_ff @(posedge clk_out) begin
        if (reset) begin
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            de_q     <= 1'b0;
            fstart_q <= 1'b0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
        end else begin
            hsync_q  <= (h_q >= HS_BEG) && (h_q < HS_END);
            vsync_q  <= (v_q >= VS_BEG) && (v_q < VS_END);
            de_q     <= (h_q < H_ACT) && (v_q < V_ACT);
            fstart_q <= pix_first && (h_q == '0) && (v_q == '0);
            hcnt_q   <= h_q;
            vcnt_q   <= v_q;
        end
    end

    assign o_hd_hsync    = hsync_q;
    assign o_hd_vsync    = vsync_q;
    assign o_hd_de       = de_q;
    assign o_frame_start = fstart_q;
    assign o_h_count     = hcnt_q;
    assign o_v_count     = vcnt_q;

endmodule

// File: tb/tb_hd_timing_gen.sv
// Bench for hd_timing_gen on a reduced raster; per-frame hold/lock
// expectations queue up as stimulus is planned and drain at each frame end.
module tb_hd_timing_gen;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 4;
    localparam int VA = 8;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int D  = 4;
    localparam int LM = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int L  = HT * D;
    localparam int F  = VT * L;

    logic        clk_out = 1'b0;
    logic        reset = 1'b1;
    logic        i_frame_end = 1'b0;
    logic        o_hd_clk;
    logic        o_hd_hsync;
    logic        o_hd_vsync;
    logic        o_hd_de;
    logic [11:0] o_h_count;
    logic [10:0] o_v_count;
    logic        o_frame_start;
    logic        o_locked;

    typedef struct {
        int hold;
        bit lock;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  cyc0 = 0;
    bit  mon_en = 1'b0;

    int          m_fbase, m_hold, m_k, m_rel;
    int          m_line, m_within, m_pix, m_h, m_v;
    bit          m_popped, m_lock_new, m_lock_exp;
    logic [27:0] m_exp, m_obs;
    sb_t         m_e;

    hd_timing_gen #(
        .H_ACTIVE       (HA),
        .H_FP           (HF),
        .H_SYNC         (HS),
        .H_BP           (HB),
        .V_ACTIVE       (VA),
        .V_FP           (VF),
        .V_SYNC         (VS),
        .V_BP           (VB),
        .CLK_DIV        (D),
        .LOCK_MAX_LINES (LM)
    ) dut (
        .clk_out       (clk_out),
        .reset         (reset),
        .i_frame_end   (i_frame_end),
        .o_hd_clk      (o_hd_clk),
        .o_hd_hsync    (o_hd_hsync),
        .o_hd_vsync    (o_hd_vsync),
        .o_hd_de       (o_hd_de),
        .o_h_count     (o_h_count),
        .o_v_count     (o_v_count),
        .o_frame_start (o_frame_start),
        .o_locked      (o_locked)
    );

    always #5 clk_out = ~clk_out;

    always @(posedge clk_out) cyc <= cyc + 1;

    // counter state index held by the DUT during the current cycle
    function automatic int st();
        return cyc - cyc0;
    endfunction

    // reference timeline: outputs after edge k decode state k
    always @(negedge clk_out) begin
        if (mon_en && st() >= 1) begin
            m_k = st() - 1;
            if (m_k == 0) begin
                m_fbase    = 0;
                m_hold     = 0;
                m_popped   = 1'b0;
                m_lock_new = 1'b0;
                m_lock_exp = 1'b0;
            end
            m_rel = m_k - m_fbase;
            if (!m_popped && m_rel == F) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_empty k=%0d observed=0 required=1", m_k);
                    m_hold     = 0;
                    m_lock_new = 1'b0;
                end else begin
                    m_e        = sb.pop_front();
                    m_hold     = m_e.hold;
                    m_lock_new = m_e.lock;
                end
                m_popped = 1'b1;
            end
            if (m_popped && m_rel == F + m_hold * L) begin
                m_fbase    = m_k;
                m_rel      = 0;
                m_popped   = 1'b0;
                m_lock_exp = m_lock_new;
            end
            m_line   = m_rel / L;
            m_within = m_rel % L;
            m_pix    = m_within % D;
            m_h      = m_within / D;
            m_v      = (m_line < VT) ? m_line : VT - 1;
            m_exp = {
                (m_pix < D / 2),
                (m_h >= HA + HF && m_h < HA + HF + HS),
                (m_v >= VA + VF && m_v < VA + VF + VS),
                (m_h < HA && m_v < VA),
                (m_rel == 0),
                12'(m_h),
                11'(m_v)
            };
            m_obs = {o_hd_clk, o_hd_hsync, o_hd_vsync, o_hd_de,
                     o_frame_start, o_h_count, o_v_count};
            checks++;
            assert (m_obs === m_exp) else begin
                errors++;
                $error("FAIL out k=%0d observed=%h expected=%h",
                       m_k, m_obs, m_exp);
            end
            if (m_rel == 5) begin
                checks++;
                assert (o_locked === m_lock_exp) else begin
                    errors++;
                    $error("FAIL locked k=%0d observed=%b expected=%b",
                           m_k, o_locked, m_lock_exp);
                end
            end
        end
    end

    task automatic push(input int hold, input bit lock);
        sb_t e;
        e.hold = hold;
        e.lock = lock;
        sb.push_back(e);
    endtask

    task automatic wait_st(input int s);
        int n = 0;
        while (st() < s && n < 200000) begin
            @(negedge clk_out);
            n++;
        end
        if (st() != s) begin
            checks++;
            errors++;
            $error("FAIL wait_st observed=%0d required=%0d", st(), s);
        end
    endtask

    task automatic pulse_at(input int s);
        wait_st(s);
        i_frame_end = 1'b1;
        @(negedge clk_out);
        i_frame_end = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        logic [28:0] obs;
        repeat (3) begin
            @(negedge clk_out);
            obs = {o_hd_clk, o_hd_hsync, o_hd_vsync, o_hd_de,
                   o_frame_start, o_locked, o_h_count, o_v_count};
            checks++;
            assert (obs === 29'd0) else begin
                errors++;
                $error("FAIL %s observed=%h expected=0", tag, obs);
            end
        end
    endtask

    task automatic release_rst();
        reset  = 1'b0;
        cyc0   = cyc;
        mon_en = 1'b1;
    endtask

    task automatic apply_reset(input string tag);
        mon_en = 1'b0;
        reset  = 1'b1;
        sb.delete();
        chk_reset(tag);
        release_rst();
    endtask

    initial begin
        chk_reset("por");
`ifdef HD_TIMING_GENLOCK_EN
        release_rst();
        // frame 0: two pulses collapse into one lock
        push(0, 1'b1);
        pulse_at(500);
        pulse_at(600);
        // frame 1: single mid-frame pulse
        push(0, 1'b1);
        pulse_at(F + 300);
        // frame 2: pulse in second hold line
        push(2, 1'b1);
        pulse_at(2 * F + F + L + 50);
        // frame 3: pulse in last hold line beats the forced wrap
        push(4, 1'b1);
        pulse_at(4400 + F + 3 * L + 10);
        // frame 4: pulse exactly on the wrap cycle
        push(0, 1'b1);
        pulse_at(6200 + F - 1);
        // frame 5: flag consumed above, so full hold and unlock
        push(4, 1'b0);
        // frame 6: pulse then mid-frame reset at v=5 h=10
        pulse_at(9400 + 300);
        wait_st(9400 + 5 * L + 10 * D);
        apply_reset("rst_mid");
        // reset cleared the pending flag
        push(4, 1'b0);
        push(0, 1'b1);
        pulse_at(F + LM * L + 200);
        wait_st(2 * F + LM * L + 100);
`else
        release_rst();
        push(0, 1'b0);
        push(0, 1'b0);
        push(0, 1'b0);
        pulse_at(700);
        pulse_at(2 * F - 1);
        wait_st(2 * F + 5 * L + 10 * D);
        apply_reset("rst_mid");
        push(0, 1'b0);
        push(0, 1'b0);
        pulse_at(300);
        wait_st(F + 100);
`endif
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
